uart_mem_cmd_ctrl: RTL and testbench

Byte-level command sequencer between the UART receiver/transmitter and the CPU's two memories. It parses host command frames, halts or resumes the pipeline via `cpu_enable`, and issues single-cycle memory write/read requests on the shared `write_mem_req`/`target_*` bus that the instruction and data memories decode. It then serializes read results or status bytes back to the UART transmitter.

---
 rtl/uart_mem_pkg.sv | 41 ++++
 rtl/uart_mem_tx_ser.sv | 62 ++++++
 rtl/uart_mem_cmd_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_mem_cmd_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_pkg
// Description : Shared constants and types for the UART memory command
//               sequencer: opcodes, reply bytes, FSM encoding, reply widths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_mem_pkg;

    // Command opcodes carried in bits [7:6] of the command byte
    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    // Single-byte status replies
    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] ERR_BYTE = 8'hEE;

    // Memory read word and its zero-extended, byte-aligned reply
    localparam int RD_W    = 42;
    localparam int REPLY_W = 48;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_DATA      = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_RESP = 3'd4,
        S_TX        = 3'd5,
        S_ACK       = 3'd6,
        S_ERR       = 3'd7
    } state_e;

    // Left-align a status byte so the serializer sends it first
    function automatic logic [REPLY_W-1:0] single_byte_reply(input logic [7:0] b);
        return {b, {(REPLY_W-8){1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mem_tx_ser.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_tx_ser
// Description : 48-bit reply serializer. Sends the top load_nbytes_i bytes of
//               load_data_i MSB first over a valid/ready byte handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_tx_ser
    import uart_mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic [REPLY_W-1:0] load_data_i,
    input  logic [2:0]         load_nbytes_i,
    input  logic               tx_ready_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    output logic               done_o
);

    logic [REPLY_W-1:0] shreg_q, shreg_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;

    // Load, shift on acceptance, and raise valid one cycle after a load
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shreg_d = load_data_i;
            cnt_d   = load_nbytes_i;
            valid_d = 1'b0;
        end else if (valid_q && tx_ready_i) begin
            shreg_d = {shreg_q[REPLY_W-9:0], 8'h00};
            cnt_d   = cnt_q - 3'd1;
            valid_d = (cnt_q > 3'd1);
        end else if (!valid_q && (cnt_q != 3'd0)) begin
            valid_d = 1'b1;
        end
    end

    // Serializer state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = shreg_q[REPLY_W-1 -: 8];
    assign tx_valid_o = valid_q;
    assign done_o     = (cnt_q == 3'd0);

endmodule
`default_nettype wire

// File: rtl/uart_mem_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_cmd_ctrl
// Description : UART command sequencer. Parses HALT/RUN/WRITE/READ frames,
//               drives cpu_enable, issues one-cycle memory requests and sends
//               ACK/ERR or 6-byte read replies back to the transmitter.
//               Define UART_MEM_CTRL_TIMEOUT_EN to enable the inter-byte and
//               read-response timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_cmd_ctrl
    import uart_mem_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT = 1000000,
    parameter int unsigned RESP_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic            cpu_enable,
    output logic            write_mem_req,
    output logic            target_mem_type,
    output logic [8:0]      target_addr,
    output logic [31:0]     wr_data,
    output logic            rw_flag,
    input  logic            instr_mem_tx_data_ready,
    input  logic [RD_W-1:0] instr_uart_tx_data,
    input  logic            data_mem_tx_data_ready,
    input  logic [RD_W-1:0] data_uart_tx_data,
    output logic            busy
);

    state_e             state_q, state_d;
    logic               cpu_en_q, cpu_en_d;
    logic               is_write_q, is_write_d;
    logic               mem_type_q, mem_type_d;
    logic               addr_hi_q, addr_hi_d;
    logic [7:0]         addr_lo_q, addr_lo_d;
    logic [31:0]        data_q, data_d;
    logic [1:0]         dcnt_q, dcnt_d;
    logic               tgt_mem_q, tgt_mem_d;
    logic [8:0]         tgt_addr_q, tgt_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic               rw_q, rw_d;
    logic               frame_done;
    logic               sel_ready;
    logic [RD_W-1:0]    sel_word;
    logic               ser_load;
    logic [REPLY_W-1:0] ser_data;
    logic [2:0]         ser_nbytes;
    logic               ser_done;

`ifdef UART_MEM_CTRL_TIMEOUT_EN
    logic [31:0]        tmo_q, tmo_d;
`else
    // Timeout lengths have no effect when the timeouts are compiled out
    logic               unused_timeouts;
    assign unused_timeouts = (BYTE_TIMEOUT != 0) ^ (RESP_TIMEOUT != 0);
`endif

    // Only the addressed memory's return path is observed
    assign sel_ready = tgt_mem_q ? instr_mem_tx_data_ready : data_mem_tx_data_ready;
    assign sel_word  = tgt_mem_q ? instr_uart_tx_data      : data_uart_tx_data;

    // Frame parser, request sequencing and reply selection
    always_comb begin
        state_d    = state_q;
        cpu_en_d   = cpu_en_q;
        is_write_d = is_write_q;
        mem_type_d = mem_type_q;
        addr_hi_d  = addr_hi_q;
        addr_lo_d  = addr_lo_q;
        data_d     = data_q;
        dcnt_d     = dcnt_q;
        tgt_mem_d  = tgt_mem_q;
        tgt_addr_d = tgt_addr_q;
        wr_data_d  = wr_data_q;
        rw_d       = rw_q;
        frame_done = 1'b0;
        ser_load   = 1'b0;
        ser_data   = '0;
        ser_nbytes = 3'd1;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data[7:6])
                        OP_HALT, OP_RUN: begin
                            cpu_en_d = (rx_data[7:6] == OP_RUN);
                            state_d  = S_ACK;
                            ser_load = 1'b1;
                            ser_data = single_byte_reply(ACK_BYTE);
                        end
                        OP_WRITE, OP_READ: begin
                            is_write_d = (rx_data[7:6] == OP_WRITE);
                            mem_type_d = rx_data[5];
                            addr_hi_d  = rx_data[0];
                            state_d    = S_ADDR;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_lo_d = rx_data;
                    if (is_write_q) begin
                        dcnt_d  = 2'd0;
                        state_d = S_DATA;
                    end else begin
                        frame_done = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_d = {data_q[23:0], rx_data};
                    dcnt_d = dcnt_q + 2'd1;
                    if (dcnt_q == 2'd3) begin
                        frame_done = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (rw_q) begin
                    state_d  = S_ACK;
                    ser_load = 1'b1;
                    ser_data = single_byte_reply(ACK_BYTE);
                end else begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (sel_ready) begin
                    state_d    = S_TX;
                    ser_load   = 1'b1;
                    ser_data   = {{(REPLY_W-RD_W){1'b0}}, sel_word};
                    ser_nbytes = 3'd6;
                end
            end
            S_TX, S_ACK, S_ERR: begin
                if (ser_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A complete memory frame is refused while the CPU is running
        if (frame_done) begin
            if (cpu_en_q) begin
                state_d  = S_ERR;
                ser_load = 1'b1;
                ser_data = single_byte_reply(ERR_BYTE);
            end else begin
                state_d    = S_ISSUE;
                tgt_mem_d  = mem_type_q;
                tgt_addr_d = {addr_hi_q, addr_lo_d};
                rw_d       = is_write_q;
                if (is_write_q) begin
                    wr_data_d = data_d;
                end
            end
        end

`ifdef UART_MEM_CTRL_TIMEOUT_EN
        if ((state_q == S_ADDR || state_q == S_DATA) && !rx_valid &&
            (tmo_q == BYTE_TIMEOUT - 1)) begin
            state_d = S_IDLE;
        end
        if (state_q == S_WAIT_RESP && !sel_ready && (tmo_q == RESP_TIMEOUT - 1)) begin
            state_d  = S_ERR;
            ser_load = 1'b1;
            ser_data = single_byte_reply(ERR_BYTE);
        end
        // Counter restarts on every state change; a received byte restarts
        // the inter-byte timer but not the response timer
        tmo_d = '0;
        if (state_d == state_q) begin
            if (state_q == S_WAIT_RESP) begin
                tmo_d = tmo_q + 32'd1;
            end else if ((state_q == S_ADDR || state_q == S_DATA) && !rx_valid) begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
    end

    // Controller state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cpu_en_q   <= 1'b1;
            is_write_q <= 1'b0;
            mem_type_q <= 1'b0;
            addr_hi_q  <= 1'b0;
            addr_lo_q  <= 8'h00;
            data_q     <= 32'h0;
            dcnt_q     <= 2'd0;
            tgt_mem_q  <= 1'b0;
            tgt_addr_q <= 9'h000;
            wr_data_q  <= 32'h0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_en_q   <= cpu_en_d;
            is_write_q <= is_write_d;
            mem_type_q <= mem_type_d;
            addr_hi_q  <= addr_hi_d;
            addr_lo_q  <= addr_lo_d;
            data_q     <= data_d;
            dcnt_q     <= dcnt_d;
            tgt_mem_q  <= tgt_mem_d;
            tgt_addr_q <= tgt_addr_d;
            wr_data_q  <= wr_data_d;
            rw_q       <= rw_d;
        end
    end

`ifdef UART_MEM_CTRL_TIMEOUT_EN
    // Shared inter-byte / response timeout counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= 32'h0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    uart_mem_tx_ser u_tx_ser (
        .clk           (clk),
        .reset         (reset),
        .load_i        (ser_load),
        .load_data_i   (ser_data),
        .load_nbytes_i (ser_nbytes),
        .tx_ready_i    (tx_ready),
        .tx_data_o     (tx_data),
        .tx_valid_o    (tx_valid),
        .done_o        (ser_done)
    );

    assign cpu_enable      = cpu_en_q;
    assign write_mem_req   = (state_q == S_ISSUE);
    assign target_mem_type = tgt_mem_q;
    assign target_addr     = tgt_addr_q;
    assign wr_data         = wr_data_q;
    assign rw_flag         = rw_q;
    assign busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mem_cmd_ctrl
// Description : Directed self-checking bench for uart_mem_cmd_ctrl with a
//               small two-memory responder and a transmit-byte collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mem_cmd_ctrl;

    localparam int unsigned TB_BYTE_TO = 64;
    localparam int unsigned TB_RESP_TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cpu_enable;
    logic        write_mem_req;
    logic        target_mem_type;
    logic [8:0]  target_addr;
    logic [31:0] wr_data;
    logic        rw_flag;
    logic        instr_mem_tx_data_ready;
    logic [41:0] instr_uart_tx_data;
    logic        data_mem_tx_data_ready;
    logic [41:0] data_uart_tx_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Responder configuration (written by the stimulus process only)
    bit          resp_en    = 1'b1;
    bit          decoy_en   = 1'b0;
    bit          rd_instr   = 1'b0;
    int          resp_delay = 0;
    logic [41:0] rd_word    = '0;
    int          resp_cnt   = -1;

    // Collected transmit bytes and memory-request snapshots
    logic [7:0]  txq[$];
    int          req_cnt = 0;
    logic        req_rw, req_mem;
    logic [8:0]  req_addr;
    logic [31:0] req_data;

    always #5 clk = ~clk;

    uart_mem_cmd_ctrl #(
        .BYTE_TIMEOUT (TB_BYTE_TO),
        .RESP_TIMEOUT (TB_RESP_TO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .rx_valid                (rx_valid),
        .rx_data                 (rx_data),
        .tx_data                 (tx_data),
        .tx_valid                (tx_valid),
        .tx_ready                (tx_ready),
        .cpu_enable              (cpu_enable),
        .write_mem_req           (write_mem_req),
        .target_mem_type         (target_mem_type),
        .target_addr             (target_addr),
        .wr_data                 (wr_data),
        .rw_flag                 (rw_flag),
        .instr_mem_tx_data_ready (instr_mem_tx_data_ready),
        .instr_uart_tx_data      (instr_uart_tx_data),
        .data_mem_tx_data_ready  (data_mem_tx_data_ready),
        .data_uart_tx_data       (data_uart_tx_data),
        .busy                    (busy)
    );

    // Accepted bytes and memory requests, sampled with pre-edge values
    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) txq.push_back(tx_data);
        if (!reset && write_mem_req) begin
            req_cnt  = req_cnt + 1;
            req_rw   = rw_flag;
            req_mem  = target_mem_type;
            req_addr = target_addr;
            req_data = wr_data;
        end
    end

    // Memory model: answers a read resp_delay cycles after the request cycle;
    // the decoy raises the other memory's ready with junk while waiting
    always @(negedge clk) begin
        instr_mem_tx_data_ready = 1'b0;
        data_mem_tx_data_ready  = 1'b0;
        instr_uart_tx_data      = 42'h15555555555;
        data_uart_tx_data       = 42'h15555555555;
        if (resp_cnt == 0) begin
            if (rd_instr) begin
                instr_mem_tx_data_ready = 1'b1;
                instr_uart_tx_data      = rd_word;
            end else begin
                data_mem_tx_data_ready  = 1'b1;
                data_uart_tx_data       = rd_word;
            end
            resp_cnt = -1;
        end else if (resp_cnt > 0) begin
            if (decoy_en) begin
                if (rd_instr) data_mem_tx_data_ready  = 1'b1;
                else          instr_mem_tx_data_ready = 1'b1;
            end
            resp_cnt = resp_cnt - 1;
        end
        if (write_mem_req && !rw_flag && resp_en) resp_cnt = resp_delay;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_valid"}, 64'(tx_valid), 64'd1);
    endtask

    // Bytes collected since base must equal the top n bytes of exp
    task automatic check_reply(input string tag, input int base, input int n, input logic [47:0] exp);
        logic [47:0] e = exp;
        check_eq({tag, "_count"}, 64'(txq.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < txq.size())
                check_eq($sformatf("%s_b%0d", tag, i), 64'(txq[base+i]), 64'(e[47-8*i -: 8]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rbase, tbase, n;
        logic [7:0] hold;
        bit stable;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_enable", 64'(cpu_enable), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_req", 64'(write_mem_req), 64'd0);
        check_eq("rst_outs", {tx_data, 7'(0), target_mem_type, rw_flag, target_addr, wr_data}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // HALT: cpu_enable drops on the sampling edge, ACK valid a cycle later
        tbase = txq.size();
        send_byte(8'h00);
        check_eq("halt_cpu_enable", 64'(cpu_enable), 64'd0);
        check_eq("halt_valid_lat0", 64'(tx_valid), 64'd0);
        @(negedge clk);
        check_eq("halt_valid_lat1", 64'(tx_valid), 64'd1);
        wait_idle("halt", 50);
        check_reply("halt_ack", tbase, 1, 48'hA50000000000);

        // WRITE to instruction memory address 0x005
        tbase = txq.size();
        rbase = req_cnt;
        send_byte(8'hA0); send_byte(8'h05); send_byte(8'hDE);
        send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        check_eq("wr_req_rise", 64'(write_mem_req), 64'd1);
        @(negedge clk);
        check_eq("wr_req_one_cycle", 64'(write_mem_req), 64'd0);
        wait_idle("wr", 50);
        check_eq("wr_req_count", 64'(req_cnt - rbase), 64'd1);
        check_eq("wr_req_fields", {req_rw, req_mem, req_addr, req_data}, {1'b1, 1'b1, 9'h005, 32'hDEADBEEF});
        check_reply("wr_ack", tbase, 1, 48'hA50000000000);
        check_eq("wr_hold", {target_mem_type, target_addr, wr_data}, {1'b1, 9'h005, 32'hDEADBEEF});

        // READ instruction memory 0x005, answer delayed by a decoy cycle
        rd_instr   = 1'b1;
        rd_word    = 42'h20BDEADBEEF;
        resp_delay = 1;
        decoy_en   = 1'b1;
        tbase = txq.size();
        rbase = req_cnt;
        send_byte(8'hE0); send_byte(8'h05);
        wait_idle("rd_i", 100);
        check_eq("rd_i_req", {32'(req_cnt - rbase), 20'(0), req_rw, req_mem, req_addr}, {32'd1, 20'(0), 1'b0, 1'b1, 9'h005});
        check_reply("rd_i_reply", tbase, 6, 48'h020BDEADBEEF);
        check_eq("rd_i_wr_data_hold", 64'(wr_data), 64'hDEADBEEF);

        // READ data memory 0x110 with the transmitter stalled for 50 cycles
        rd_instr = 1'b0;
        rd_word  = 42'h15512345678;
        tx_ready = 1'b0;
        tbase = txq.size();
        send_byte(8'hC1); send_byte(8'h10);
        wait_valid("rd_d_stall", 40);
        hold   = tx_data;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx_data !== hold || tx_valid !== 1'b1) stable = 1'b0;
        end
        check_eq("rd_d_stall_stable", 64'(stable), 64'd1);
        check_eq("rd_d_stall_byte", 64'(hold), 64'h01);
        tx_ready = 1'b1;
        wait_idle("rd_d", 100);
        check_eq("rd_d_target", {req_mem, req_addr}, {1'b0, 9'h110});
        check_reply("rd_d_reply", tbase, 6, 48'h015512345678);

        // A RUN byte arriving during ACK is dropped
        tx_ready = 1'b0;
        tbase = txq.size();
        send_byte(8'h00);
        send_byte(8'h40);
        check_eq("drop_cpu_enable", 64'(cpu_enable), 64'd0);
        tx_ready = 1'b1;
        wait_idle("drop", 50);
        repeat (3) @(negedge clk);
        check_eq("drop_cpu_enable_after", 64'(cpu_enable), 64'd0);
        check_reply("drop_ack", tbase, 1, 48'hA50000000000);

        // RUN, then memory frames are refused with ERR
        tbase = txq.size();
        send_byte(8'h40);
        check_eq("run_cpu_enable", 64'(cpu_enable), 64'd1);
        wait_idle("run", 50);
        check_reply("run_ack", tbase, 1, 48'hA50000000000);
        tbase = txq.size();
        rbase = req_cnt;
        send_byte(8'hC1); send_byte(8'h10);
        wait_idle("run_rd", 50);
        check_reply("run_rd_err", tbase, 1, 48'hEE0000000000);
        tbase = txq.size();
        send_byte(8'h80); send_byte(8'h00); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        wait_idle("run_wr", 50);
        check_reply("run_wr_err", tbase, 1, 48'hEE0000000000);
        check_eq("run_no_req", 64'(req_cnt - rbase), 64'd0);
        check_eq("run_wr_data_hold", 64'(wr_data), 64'hDEADBEEF);
        tbase = txq.size();
        send_byte(8'h40);
        wait_idle("run2", 50);
        check_eq("run2_cpu_enable", 64'(cpu_enable), 64'd1);
        check_reply("run2_ack", tbase, 1, 48'hA50000000000);

        // Reset in the middle of a stalled read reply
        send_byte(8'h00);
        wait_idle("rst_halt", 50);
        rd_instr = 1'b1;
        rd_word  = 42'h20BDEADBEEF;
        tx_ready = 1'b0;
        send_byte(8'hE0); send_byte(8'h05);
        wait_valid("rst_mid", 40);
        tbase = txq.size();
        reset = 1'b1;
        #1;
        check_eq("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        check_eq("rst_mid_cpu_enable", 64'(cpu_enable), 64'd1);
        @(negedge clk);
        reset    = 1'b0;
        tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_mid_no_tx", 64'(txq.size() - tbase) | 64'(tx_valid), 64'd0);
        tbase = txq.size();
        send_byte(8'h00);
        wait_idle("rst_recover", 50);
        check_reply("rst_recover_ack", tbase, 1, 48'hA50000000000);

`ifdef UART_MEM_CTRL_TIMEOUT_EN
        // READ with no response: ERR after the response timeout
        resp_en = 1'b0;
        tbase = txq.size();
        send_byte(8'hE0); send_byte(8'h05);
        n = 0;
        while (!tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("resp_to_latency", 64'(n), 64'd18);
        wait_idle("resp_to", 50);
        check_reply("resp_to_err", tbase, 1, 48'hEE0000000000);
        resp_en = 1'b1;

        // Partial frame followed by silence is dropped without a reply
        tbase = txq.size();
        rbase = req_cnt;
        send_byte(8'h80);
        repeat (TB_BYTE_TO / 2) @(negedge clk);
        check_eq("byte_to_still_busy", 64'(busy), 64'd1);
        wait_idle("byte_to", 200);
        check_eq("byte_to_silent", 64'(txq.size() - tbase) + 64'(req_cnt - rbase), 64'd0);
`else
        // Without timeouts a partial frame waits indefinitely, then completes
        tbase = txq.size();
        send_byte(8'h80);
        repeat (200) @(negedge clk);
        check_eq("no_to_still_busy", 64'(busy), 64'd1);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        wait_idle("no_to", 50);
        check_eq("no_to_write", {target_mem_type, target_addr, wr_data}, {1'b0, 9'h000, 32'h11223344});
        check_reply("no_to_ack", tbase, 1, 48'hA50000000000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
